// File: rtl/nav_loop_sequencer_if.sv
// rtl/nav_loop_sequencer_if.sv - helper and ultrasound start/done handshake bundle for the navigation sequencer
interface nav_loop_sequencer_if #(
    parameter int LW       = 12,
    parameter int ORIENT_W = 5
);
    logic                run_ultrasound;
    logic                ultrasound_done;
    logic [LW-1:0]       helper_loc_a;
    logic [LW-1:0]       helper_loc_b;
    logic                orient_start;
    logic                orient_done;
    logic [ORIENT_W-1:0] orient_result;
    logic                path_start;
    logic                path_done;
    logic [LW-1:0]       path_cmd;
    logic [ORIENT_W-1:0] needed_orientation;
    logic                cmp_start;
    logic                cmp_done;
    logic                cmp_equal;

    modport master (
        output run_ultrasound, helper_loc_a, helper_loc_b, orient_start,
               path_start, needed_orientation, cmp_start,
        input  ultrasound_done, orient_done, orient_result, path_done,
               path_cmd, cmp_done, cmp_equal
    );

    modport slave (
        input  run_ultrasound, helper_loc_a, helper_loc_b, orient_start,
               path_start, needed_orientation, cmp_start,
        output ultrasound_done, orient_done, orient_result, path_done,
               path_cmd, cmp_done, cmp_equal
    );
endinterface

// File: rtl/nav_loop_sequencer.sv
// rtl/nav_loop_sequencer.sv - closed-loop rover navigation sequencer; NAV_US_TIMEOUT_EN adds ultrasound timeout/retry
module nav_loop_sequencer #(
    parameter int          R_W            = 8,
    parameter int          TH_W           = 4,
    parameter int          ORIENT_W       = 5,
    parameter int          MAX_ITER       = 4,
    parameter int          SETTLE_CYCLES  = 27000000,
    parameter int          IR_HOLD_CYCLES = 5000000,
    parameter int          TICKS_PER_UNIT = 27000000,
`ifdef NAV_US_TIMEOUT_EN
    parameter int          US_TIMEOUT_CYCLES = 54000000,
    parameter int          US_RETRIES        = 2,
`endif
    parameter logic [11:0] PROBE_CMD      = 12'h00A
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     run_program,
    input  logic [TH_W+R_W-1:0]      target_location,
    input  logic [TH_W+R_W-1:0]      rover_location,
    nav_loop_sequencer_if.master     hs,
    output logic [ORIENT_W-1:0]      orientation,
    output logic [TH_W+R_W-1:0]      move_command,
    output logic                     transmit_ir,
    output logic                     reached_target,
    output logic                     failed,
    output logic [7:0]               iteration,
    output logic [3:0]               state
);
    localparam int LW = TH_W + R_W;
    localparam int UW = R_W + 1;
    localparam logic [LW-1:0] PROBE_LW = LW'(PROBE_CMD);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        LOC_1       = 4'd1,
        SETTLE_1    = 4'd2,
        PROBE_TX    = 4'd3,
        PROBE_WAIT  = 4'd4,
        LOC_2       = 4'd5,
        SETTLE_2    = 4'd6,
        ORIENT_CALC = 4'd7,
        AIM_CALC    = 4'd8,
        PATH_CALC   = 4'd9,
        MOVE_TX     = 4'd10,
        MOVE_WAIT   = 4'd11,
        LOC_3       = 4'd12,
        CHECK       = 4'd13,
        DONE        = 4'd14,
        FAIL        = 4'd15
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [UW-1:0]       units_q, units_d;
    logic [LW-1:0]       loc_a_q, loc_a_d;
    logic [LW-1:0]       loc_b_q, loc_b_d;
    logic [ORIENT_W-1:0] orientation_q, orientation_d;
    logic [ORIENT_W-1:0] needed_q, needed_d;
    logic [LW-1:0]       move_command_q, move_command_d;
    logic                transmit_ir_q, transmit_ir_d;
    logic                reached_q, reached_d;
    logic                failed_q, failed_d;
    logic [7:0]          iteration_q, iteration_d;
    logic                run_us_q, run_us_d;
    logic                orient_start_q, orient_start_d;
    logic                path_start_q, path_start_d;
    logic                cmp_start_q, cmp_start_d;
`ifdef NAV_US_TIMEOUT_EN
    logic [7:0]          retry_q, retry_d;
`endif

    // Move duration in units: distance + turn + 1, widened so 255+15+1 does not wrap.
    logic [UW-1:0] move_units;
    assign move_units = UW'(move_command_q[R_W-1:0]) + UW'(move_command_q[LW-1:R_W]) + UW'(1);

    // Next-state and datapath decisions; every start output is a registered one-cycle pulse.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 32'd1;
        units_d        = units_q;
        loc_a_d        = loc_a_q;
        loc_b_d        = loc_b_q;
        orientation_d  = orientation_q;
        needed_d       = needed_q;
        move_command_d = move_command_q;
        transmit_ir_d  = transmit_ir_q;
        reached_d      = reached_q;
        failed_d       = failed_q;
        iteration_d    = iteration_q;
        run_us_d       = 1'b0;
        orient_start_d = 1'b0;
        path_start_d   = 1'b0;
        cmp_start_d    = 1'b0;
`ifdef NAV_US_TIMEOUT_EN
        retry_d        = retry_q;
`endif
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (run_program) begin
                    reached_d      = 1'b0;
                    failed_d       = 1'b0;
                    iteration_d    = 8'd0;
                    orientation_d  = '0;
                    move_command_d = '0;
                    run_us_d       = 1'b1;
                    state_d        = LOC_1;
                end
            end
            LOC_1, LOC_2, LOC_3: begin
                // A done arriving in the same cycle as our start pulse belongs to nothing we asked for.
                if (hs.ultrasound_done && !run_us_q) begin
`ifdef NAV_US_TIMEOUT_EN
                    retry_d = 8'd0;
`endif
                    if (state_q == LOC_1) begin
                        state_d = SETTLE_1;
                    end else if (state_q == LOC_2) begin
                        state_d = SETTLE_2;
                    end else begin
                        loc_a_d     = rover_location;
                        loc_b_d     = target_location;
                        cmp_start_d = 1'b1;
                        state_d     = CHECK;
                    end
                end
`ifdef NAV_US_TIMEOUT_EN
                else if (cnt_q == 32'(US_TIMEOUT_CYCLES - 1)) begin
                    if (retry_q == 8'(US_RETRIES)) begin
                        failed_d = 1'b1;
                        state_d  = FAIL;
                    end else begin
                        retry_d  = retry_q + 8'd1;
                        run_us_d = 1'b1;
                        cnt_d    = 32'd0;
                    end
                end
`endif
            end
            SETTLE_1: begin
                if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                    loc_a_d        = rover_location;
                    move_command_d = PROBE_LW;
                    transmit_ir_d  = 1'b1;
                    state_d        = PROBE_TX;
                end
            end
            PROBE_TX, MOVE_TX: begin
                if (cnt_q == 32'(IR_HOLD_CYCLES - 1)) begin
                    transmit_ir_d = 1'b0;
                    if (state_q == PROBE_TX) begin
                        units_d = UW'(PROBE_LW[R_W-1:0]);
                        state_d = PROBE_WAIT;
                    end else begin
                        units_d = move_units;
                        state_d = MOVE_WAIT;
                    end
                end
            end
            PROBE_WAIT, MOVE_WAIT: begin
                // cnt_q is the tick within a unit; units_q counts remaining units (0 behaves as 1).
                if (cnt_q == 32'(TICKS_PER_UNIT - 1)) begin
                    if (units_q <= UW'(1)) begin
                        run_us_d = 1'b1;
                        state_d  = (state_q == PROBE_WAIT) ? LOC_2 : LOC_3;
                    end else begin
                        units_d = units_q - UW'(1);
                        cnt_d   = 32'd0;
                    end
                end
            end
            SETTLE_2: begin
                if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                    loc_b_d        = rover_location;
                    orient_start_d = 1'b1;
                    state_d        = ORIENT_CALC;
                end
            end
            ORIENT_CALC: begin
                if (hs.orient_done && !orient_start_q) begin
                    orientation_d  = hs.orient_result;
                    loc_a_d        = loc_b_q;
                    loc_b_d        = target_location;
                    orient_start_d = 1'b1;
                    state_d        = AIM_CALC;
                end
            end
            AIM_CALC: begin
                if (hs.orient_done && !orient_start_q) begin
                    needed_d     = hs.orient_result;
                    path_start_d = 1'b1;
                    state_d      = PATH_CALC;
                end
            end
            PATH_CALC: begin
                if (hs.path_done && !path_start_q) begin
                    move_command_d = hs.path_cmd;
                    transmit_ir_d  = 1'b1;
                    state_d        = MOVE_TX;
                end
            end
            CHECK: begin
                if (hs.cmp_done && !cmp_start_q) begin
                    iteration_d = (iteration_q == 8'hFF) ? 8'hFF : iteration_q + 8'd1;
                    if (hs.cmp_equal) begin
                        reached_d = 1'b1;
                        state_d   = DONE;
                    end else if (({1'b0, iteration_q} + 9'd1) == 9'(MAX_ITER)) begin
                        failed_d = 1'b1;
                        state_d  = FAIL;
                    end else begin
                        run_us_d = 1'b1;
                        state_d  = LOC_1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = 32'd0;
        end
    end

    // State and datapath registers; reset aborts immediately with every output low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= 32'd0;
            units_q        <= '0;
            loc_a_q        <= '0;
            loc_b_q        <= '0;
            orientation_q  <= '0;
            needed_q       <= '0;
            move_command_q <= '0;
            transmit_ir_q  <= 1'b0;
            reached_q      <= 1'b0;
            failed_q       <= 1'b0;
            iteration_q    <= 8'd0;
            run_us_q       <= 1'b0;
            orient_start_q <= 1'b0;
            path_start_q   <= 1'b0;
            cmp_start_q    <= 1'b0;
`ifdef NAV_US_TIMEOUT_EN
            retry_q        <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            units_q        <= units_d;
            loc_a_q        <= loc_a_d;
            loc_b_q        <= loc_b_d;
            orientation_q  <= orientation_d;
            needed_q       <= needed_d;
            move_command_q <= move_command_d;
            transmit_ir_q  <= transmit_ir_d;
            reached_q      <= reached_d;
            failed_q       <= failed_d;
            iteration_q    <= iteration_d;
            run_us_q       <= run_us_d;
            orient_start_q <= orient_start_d;
            path_start_q   <= path_start_d;
            cmp_start_q    <= cmp_start_d;
`ifdef NAV_US_TIMEOUT_EN
            retry_q        <= retry_d;
`endif
        end
    end

    assign hs.run_ultrasound     = run_us_q;
    assign hs.helper_loc_a       = loc_a_q;
    assign hs.helper_loc_b       = loc_b_q;
    assign hs.orient_start       = orient_start_q;
    assign hs.path_start         = path_start_q;
    assign hs.needed_orientation = needed_q;
    assign hs.cmp_start          = cmp_start_q;

    assign orientation    = orientation_q;
    assign move_command   = move_command_q;
    assign transmit_ir    = transmit_ir_q;
    assign reached_target = reached_q;
    assign failed         = failed_q;
    assign iteration      = iteration_q;
    assign state          = state_q;
endmodule

// File: tb/tb_nav_loop_sequencer.sv
// tb/tb_nav_loop_sequencer.sv - self-checking bench for nav_loop_sequencer
module tb_nav_loop_sequencer;
    localparam int LW = 12;
    localparam int BUDGET = 3000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run_program = 1'b0;
    logic [11:0] target_location = 12'h000;
    logic [11:0] rover_location = 12'h000;
    logic [4:0]  orientation;
    logic [11:0] move_command;
    logic        transmit_ir;
    logic        reached_target;
    logic        failed;
    logic [7:0]  iteration;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    nav_loop_sequencer_if #(.LW(LW), .ORIENT_W(5)) hs();

    nav_loop_sequencer #(
        .R_W(8), .TH_W(4), .ORIENT_W(5), .MAX_ITER(2),
        .SETTLE_CYCLES(4), .IR_HOLD_CYCLES(3), .TICKS_PER_UNIT(5),
`ifdef NAV_US_TIMEOUT_EN
        .US_TIMEOUT_CYCLES(10), .US_RETRIES(2),
`endif
        .PROBE_CMD(12'h00A)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .run_program(run_program),
        .target_location(target_location),
        .rover_location(rover_location),
        .hs(hs),
        .orientation(orientation),
        .move_command(move_command),
        .transmit_ir(transmit_ir),
        .reached_target(reached_target),
        .failed(failed),
        .iteration(iteration),
        .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] path_cmd;
        logic [1:0]  eq;
        bit          glitch;
        bit          abort;
        int          exp_reached;
        int          exp_failed;
        int          exp_iter;
        int          exp_state;
        int          exp_us;
        int          exp_ir;
        int          exp_mwait;
        int          exp_pwait;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hs.ultrasound_done = 1'b0;
        hs.orient_done     = 1'b0;
        hs.orient_result   = 5'h00;
        hs.path_done       = 1'b0;
        hs.path_cmd        = 12'h000;
        hs.cmp_done        = 1'b0;
        hs.cmp_equal       = 1'b0;
        run_program        = 1'b0;
    endtask

    task automatic quiet_check(input string name, input int cycles);
        int us = 0;
        int ir = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (hs.run_ultrasound) us++;
            if (transmit_ir) ir++;
        end
        check({name, "_quiet_us"}, us, 0);
        check({name, "_quiet_ir"}, ir, 0);
    endtask

    // Plays every helper for one run and compares the run's outcome to the vector.
    task automatic run_vec(input vec_t v, input int idx);
        int us_pulses = 0, ir_total = 0, mwait = 0, pwait = 0;
        int pass = 0, ostart = 0;
        int us_dly = 0, o_dly = 0, p_dly = 0, c_dly = 0;
        bit finished = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        target_location = 12'h100 + 12'(idx);
        hs.path_cmd = v.path_cmd;
        @(negedge clock);
        run_program = 1'b1;
        @(negedge clock);
        run_program = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            hs.ultrasound_done = 1'b0;
            hs.orient_done     = 1'b0;
            hs.path_done       = 1'b0;
            hs.cmp_done        = 1'b0;
            if (transmit_ir) ir_total++;
            if (state == 4'd11) mwait++;
            if (state == 4'd4) pwait++;
            if (hs.run_ultrasound) begin
                us_pulses++;
                us_dly = 2;
            end else if (us_dly > 0) begin
                us_dly--;
                if (us_dly == 0) begin
                    hs.ultrasound_done = 1'b1;
                    rover_location = rover_location + 12'h011;
                end
            end
            if (hs.orient_start) begin
                ostart++;
                if (ostart % 2 == 1) begin
                    check({tag, "_orient1_loc_a"}, hs.helper_loc_a, rover_location - 12'h011);
                    check({tag, "_orient1_loc_b"}, hs.helper_loc_b, rover_location);
                end else begin
                    check({tag, "_orient2_loc_a"}, hs.helper_loc_a, rover_location);
                    check({tag, "_orient2_loc_b"}, hs.helper_loc_b, target_location);
                end
                if (v.glitch) begin
                    hs.orient_done   = 1'b1;
                    hs.orient_result = (ostart % 2 == 1) ? 5'h1F : 5'h1E;
                end
                o_dly = v.glitch ? 3 : 1;
            end else if (o_dly > 0) begin
                o_dly--;
                if (o_dly == 0) begin
                    hs.orient_done   = 1'b1;
                    hs.orient_result = (ostart % 2 == 1) ? 5'h07 : 5'h0C;
                end
            end
            if (hs.path_start) begin
                p_dly = 1;
            end else if (p_dly > 0) begin
                p_dly--;
                if (p_dly == 0) hs.path_done = 1'b1;
            end
            if (hs.cmp_start) begin
                check({tag, "_cmp_loc_a"}, hs.helper_loc_a, rover_location);
                check({tag, "_cmp_loc_b"}, hs.helper_loc_b, target_location);
                c_dly = 1;
            end else if (c_dly > 0) begin
                c_dly--;
                if (c_dly == 0) begin
                    hs.cmp_done  = 1'b1;
                    hs.cmp_equal = (pass < 2) ? v.eq[pass] : 1'b0;
                    pass++;
                end
            end
            if (v.abort && state == 4'd10) begin
                check({tag, "_ir_before_abort"}, transmit_ir, 1);
                #2;
                reset_n = 1'b0;
                #1;
                check({tag, "_abort_ir"}, transmit_ir, 0);
                check({tag, "_abort_state"}, state, 0);
                check({tag, "_abort_us"}, hs.run_ultrasound, 0);
                check({tag, "_abort_cmd"}, move_command, 0);
                check({tag, "_abort_orient"}, orientation, 0);
                check({tag, "_abort_needed"}, hs.needed_orientation, 0);
                check({tag, "_abort_flags"}, {reached_target, failed, iteration}, 0);
                finished = 1;
            end else if (state == 4'd14 || state == 4'd15) begin
                finished = 1;
            end
            if (!finished) @(negedge clock);
        end
        if (!finished) begin
            check({tag, "_run_ended"}, 0, 1);
            return;
        end
        if (v.abort) begin
            clear_inputs();
            repeat (3) @(negedge clock);
            check({tag, "_held_state"}, state, 0);
            reset_n = 1'b1;
            quiet_check(tag, 30);
            check({tag, "_post_state"}, state, 0);
            return;
        end
        check({tag, "_reached"}, reached_target, v.exp_reached);
        check({tag, "_failed"}, failed, v.exp_failed);
        check({tag, "_iter"}, iteration, v.exp_iter);
        check({tag, "_state"}, state, v.exp_state);
        check({tag, "_us_pulses"}, us_pulses, v.exp_us);
        check({tag, "_ir_cycles"}, ir_total, v.exp_ir);
        check({tag, "_move_wait"}, mwait, v.exp_mwait);
        check({tag, "_probe_wait"}, pwait, v.exp_pwait);
        check({tag, "_move_cmd"}, move_command, v.path_cmd);
        check({tag, "_orientation"}, orientation, 5'h07);
        check({tag, "_needed"}, hs.needed_orientation, 5'h0C);
        quiet_check(tag, 20);
        check({tag, "_flags_hold"}, {reached_target, failed}, {1'(v.exp_reached), 1'(v.exp_failed)});
    endtask

    initial begin
        //            cmd      eq     gl  ab  rch fl it st  us ir  mwait pwait
        vecs[0] = '{12'h201, 2'b01, 0, 0, 1, 0, 1, 14, 3, 6,  20,   50};
        vecs[1] = '{12'h201, 2'b10, 0, 0, 1, 0, 2, 14, 6, 12, 40,   100};
        vecs[2] = '{12'h000, 2'b00, 0, 0, 0, 1, 2, 15, 6, 12, 10,   100};
        vecs[3] = '{12'hFFF, 2'b01, 0, 0, 1, 0, 1, 14, 3, 6,  1355, 50};
        vecs[4] = '{12'h0FF, 2'b01, 0, 0, 1, 0, 1, 14, 3, 6,  1280, 50};
        vecs[5] = '{12'h3A2, 2'b01, 1, 0, 1, 0, 1, 14, 3, 6,  830,  50};
        vecs[6] = '{12'h201, 2'b01, 0, 1, 0, 0, 0, 0,  0, 0,  0,    0};

        clear_inputs();
        repeat (3) @(negedge clock);
        check("reset_state", state, 0);
        check("reset_outputs", {transmit_ir, reached_target, failed, iteration, move_command, orientation}, 0);
        check("reset_pulses", {hs.run_ultrasound, hs.orient_start, hs.path_start, hs.cmp_start}, 0);
        reset_n = 1'b1;
        quiet_check("idle", 5);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // run_program in the middle of a run must not restart it.
        hs.path_cmd = 12'h201;
        @(negedge clock);
        run_program = 1'b1;
        @(negedge clock);
        run_program = 1'b0;
        repeat (3) @(negedge clock);
        run_program = 1'b1;
        @(negedge clock);
        run_program = 1'b0;
        check("busy_ignore_run", state, 4'd1);
        reset_n = 1'b0;
        #1;
        clear_inputs();
        @(negedge clock);
        reset_n = 1'b1;

`ifdef NAV_US_TIMEOUT_EN
        begin
            int pulses = 0;
            int first = -1;
            int last = -1;
            bit gap_ok = 1;
            @(negedge clock);
            run_program = 1'b1;
            @(negedge clock);
            run_program = 1'b0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (hs.run_ultrasound) begin
                    if (last >= 0 && cyc - last != 10) gap_ok = 0;
                    if (first < 0) first = cyc;
                    last = cyc;
                    pulses++;
                end
                @(negedge clock);
            end
            check("to_pulses", pulses, 3);
            check("to_gap", gap_ok, 1);
            check("to_span", last - first, 20);
            check("to_failed", failed, 1);
            check("to_state", state, 15);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
